// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter/sequencer.
package alu_arb_pkg;

    localparam int OP_W       = 4;
    localparam int FLAG_W     = 3;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Packs the ALU status lines into the {OVERFLOW, CARRY, ZERO} response field.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic zero,
        input logic carry,
        input logic ovf
    );
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin grant: a sole requester wins outright, a tie goes to
// the requester that was not served last.
module alu_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |valid;
        gnt       = 1'b0;
        if (&valid) begin
            gnt = ~last_gnt;
        end else begin
            gnt = valid[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation in flight.
// Optional BUSY watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CK_REF,
    input  logic              RST_N,

    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [OP_W-1:0]   REQ0_OP,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,

    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [OP_W-1:0]   REQ1_OP,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,

    output logic              RSP0_VALID,
    output logic [DATA_W-1:0] RSP0_RESULT,
    output logic [FLAG_W-1:0] RSP0_FLAGS,
    output logic              RSP0_ERR,

    output logic              RSP1_VALID,
    output logic [DATA_W-1:0] RSP1_RESULT,
    output logic [FLAG_W-1:0] RSP1_FLAGS,
    output logic              RSP1_ERR,

    output logic              ALU_EN,
    output logic [OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              ALU_ZERO,
    input  logic              ALU_CARRY,
    input  logic              ALU_OVF,
    input  logic              ALU_DONE
);

    arb_state_e        state_q, state_d;
    logic              arb_gnt, arb_gnt_valid;
    logic              accept;
    logic              busy;
    logic              timeout_hit;
    logic              gnt_q;
    logic              last_gnt_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] result_q;
    logic [FLAG_W-1:0] flags_q;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    alu_rr_arbiter u_rr (
        .valid     ({REQ1_VALID, REQ0_VALID}),
        .last_gnt  (last_gnt_q),
        .gnt       (arb_gnt),
        .gnt_valid (arb_gnt_valid)
    );

    assign busy   = (state_q == ST_BUSY);
    assign accept = (state_q == ST_IDLE) && arb_gnt_valid;
    assign sel_op = arb_gnt ? REQ1_OP : REQ0_OP;
    assign sel_a  = arb_gnt ? REQ1_A  : REQ0_A;
    assign sel_b  = arb_gnt ? REQ1_B  : REQ0_B;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt_q;
    logic             err_q;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            busy_cnt_q <= '0;
        end else if (accept) begin
            busy_cnt_q <= '0;
        end else if (busy) begin
            busy_cnt_q <= busy_cnt_q + CNT_W'(1);
        end
    end

    // The count reads N-1 during the Nth BUSY cycle, so the limit fires on the last allowed one.
    assign timeout_hit = busy && !ALU_DONE && (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (busy && ALU_DONE) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign RSP0_ERR = RSP0_VALID && err_q;
    assign RSP1_ERR = RSP1_VALID && err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign RSP0_ERR           = 1'b0;
    assign RSP1_ERR           = 1'b0;
`endif

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                   state_d = ST_BUSY;
            ST_BUSY: if (ALU_DONE || timeout_hit)  state_d = ST_RESP;
            ST_RESP:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Request latches, result capture and round-robin history.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            if (accept) begin
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                gnt_q <= arb_gnt;
            end
            if (busy && ALU_DONE) begin
                result_q <= ALU_OUT;
                flags_q  <= pack_flags(ALU_ZERO, ALU_CARRY, ALU_OVF);
            end else if (timeout_hit) begin
                result_q <= '0;
                flags_q  <= '0;
            end
            if (state_q == ST_RESP) begin
                last_gnt_q <= gnt_q;
            end
        end
    end

    assign REQ0_READY = accept && !arb_gnt;
    assign REQ1_READY = accept &&  arb_gnt;

    assign ALU_EN = busy;
    assign ALU_OP = busy ? op_q : '0;
    assign ALU_A  = busy ? a_q  : '0;
    assign ALU_B  = busy ? b_q  : '0;

    assign RSP0_VALID  = (state_q == ST_RESP) && !gnt_q;
    assign RSP1_VALID  = (state_q == ST_RESP) &&  gnt_q;
    assign RSP0_RESULT = RSP0_VALID ? result_q : '0;
    assign RSP1_RESULT = RSP1_VALID ? result_q : '0;
    assign RSP0_FLAGS  = RSP0_VALID ? flags_q  : '0;
    assign RSP1_FLAGS  = RSP1_VALID ? flags_q  : '0;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer sitting in front of the shared `alu`. Accepts operation requests from two requesters (e.g. execute stage and address-generation logic), grants the ALU round-robin, drives `ALU_EN`/op/operands, waits for `ALU_DONE`, and returns the latched result and flags to the granted requester. One operation in flight at a time.

## Interface
- `DATA_W`, 32, operand/result width
- `TIMEOUT_CYCLES`, 16, watchdog limit in BUSY cycles (used only with macro)

- `CK_REF` in 1 clock, rising edge
- `RST_N` in 1 asynchronous, active-low reset
- `REQn_VALID` in 1 (n=0,1) request present
- `REQn_READY` out 1 request accepted this cycle
- `REQn_OP` in 4 ALU op code (ALU encoding, e.g. 4'b0001 = add)
- `REQn_A`, `REQn_B` in DATA_W operands
- `RSPn_VALID` out 1 one-cycle response strobe
- `RSPn_RESULT` out DATA_W result
- `RSPn_FLAGS` out 3 {OVERFLOW, CARRY, ZERO}
- `RSPn_ERR` out 1 watchdog timeout
- `ALU_EN` out 1, `ALU_OP` out 4, `ALU_A`/`ALU_B` out DATA_W: to ALU
- `ALU_OUT` in DATA_W, `ALU_ZERO`/`ALU_CARRY`/`ALU_OVF`/`ALU_DONE` in 1: from ALU

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: grant = sole valid requester; if both valid, the one not served last (`last_gnt`). `REQn_READY` = IDLE && grant==n (combinational). On VALID&&READY: latch op/A/B and grant id, go BUSY.
- BUSY: `ALU_EN`=1; `ALU_OP/A/B` driven from latches, stable for whole state. When `ALU_DONE`=1: capture `ALU_OUT` and flags, go RESP.
- RESP: `RSPg_VALID`=1 for granted requester only; `last_gnt`<=grant; go IDLE. Other requester's RSP outputs stay 0.
- `RSPn_RESULT/FLAGS` are registered; valid only while `RSPn_VALID`; held 0 otherwise.
- Requests are not queued: a requester holds VALID and payload until READY.
- `ALU_DONE` ignored outside BUSY.

## Timing
- Reset values: all outputs 0; state IDLE; `last_gnt`=1 (requester 0 wins first tie).
- Reset assertion mid-operation: outputs return to 0 asynchronously, in-flight op dropped, no response issued.
- Latency: accept at cycle c0; c1 BUSY (`ALU_EN`=1); if `ALU_DONE` at c1, `RSP_VALID` at c2; IDLE and next accept at c3. Minimum 3 cycles per op; each extra `ALU_DONE` delay cycle adds one.
- Simultaneous VALIDs: strict alternation while both stay asserted.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined: counter clears on BUSY entry, increments each BUSY cycle; if it reaches `TIMEOUT_CYCLES` without `ALU_DONE`, go RESP with `RSPg_ERR`=1, RESULT=0, FLAGS=0; `ALU_EN` drops.
- Undefined: no counter; BUSY waits indefinitely; `RSPn_ERR` tied 0.

## Structure
- Package `alu_arb_pkg`: state enum, `OP_W`=4, flag bit indices (ZERO=0, CARRY=1, OVF=2).
- Sub-module `alu_rr_arbiter`: 2-way round-robin grant from valids and `last_gnt`.

## Test plan
- REQ0 add A=5,B=6, ALU done in first BUSY cycle -> `RSP0_VALID` at c2, RESULT=11, FLAGS=3'b000.
- After reset both VALID: REQ0 add 15+100, REQ1 add 0xFFFFFFFF+1 -> REQ0 served first (115, 3'b000), then REQ1 (0, FLAGS=3'b011).
- Both held valid for 4 ops -> grants alternate 0,1,0,1; no RSP to non-granted port.
- ALU_DONE delayed 5 cycles (9000+8192) -> `ALU_EN` and operands stable 5 cycles, RESULT=17192 one cycle after DONE.
- RST_N low during BUSY -> `ALU_EN`=0 immediately, no RSP; post-reset REQ1 alone served normally.
- With `ALU_ARB_TIMEOUT_EN`, DONE never asserted -> after 16 BUSY cycles `RSP0_VALID`=1, `RSP0_ERR`=1, RESULT=0.
